// File: rtl/mem_access_pkg.sv
// rtl/mem_access_pkg.sv - shared widths, aluop codes, exception bits, size codes and FSM states
package mem_access_pkg;

  localparam int GPR_BUS        = 32;
  localparam int ALUOP_BUS      = 8;
  localparam int EXCEP_TYPE_BUS = 32;
  localparam int RAM_ADDR_BUS   = 32;

  // Memory aluop encodings; anything else is a non-memory op.
  localparam logic [ALUOP_BUS-1:0] ALUOP_LB  = 8'h01;
  localparam logic [ALUOP_BUS-1:0] ALUOP_LBU = 8'h02;
  localparam logic [ALUOP_BUS-1:0] ALUOP_LH  = 8'h03;
  localparam logic [ALUOP_BUS-1:0] ALUOP_LHU = 8'h04;
  localparam logic [ALUOP_BUS-1:0] ALUOP_LW  = 8'h05;
  localparam logic [ALUOP_BUS-1:0] ALUOP_SB  = 8'h06;
  localparam logic [ALUOP_BUS-1:0] ALUOP_SH  = 8'h07;
  localparam logic [ALUOP_BUS-1:0] ALUOP_SW  = 8'h08;
  localparam logic [ALUOP_BUS-1:0] ALUOP_ADD = 8'h10;

  localparam int EXCEP_ADEL_BIT = 4;
  localparam int EXCEP_ADES_BIT = 5;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_DATA = 2'd1,
    ST_DONE      = 2'd2,
    ST_DRAIN     = 2'd3
  } state_e;

endpackage

// File: rtl/mem_access_if.sv
// rtl/mem_access_if.sv - SRAM-like data bus between the memory stage and the interconnect
interface mem_access_if;
  import mem_access_pkg::*;

  logic                    data_req;
  logic                    data_wr;
  logic [1:0]              data_size;
  logic [RAM_ADDR_BUS-1:0] data_addr;
  logic [GPR_BUS-1:0]      data_wdata;
  logic                    data_addr_ok;
  logic                    data_ok;
  logic [GPR_BUS-1:0]      data_rdata;

  modport master (
    output data_req, data_wr, data_size, data_addr, data_wdata,
    input  data_addr_ok, data_ok, data_rdata
  );

  modport slave (
    input  data_req, data_wr, data_size, data_addr, data_wdata,
    output data_addr_ok, data_ok, data_rdata
  );
endinterface

// File: rtl/mem_access_load_align.sv
// rtl/mem_access_load_align.sv - load lane select and sign/zero extension
module mem_access_load_align
  import mem_access_pkg::*;
(
  input  logic [ALUOP_BUS-1:0] aluop_i,
  input  logic [1:0]           addr_lo_i,
  input  logic [GPR_BUS-1:0]   rdata_i,
  output logic [GPR_BUS-1:0]   result_o
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  // Pick the addressed byte/half out of the word-aligned read data, then extend.
  always_comb begin
    byte_lane = rdata_i[8*addr_lo_i +: 8];
    half_lane = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    case (aluop_i)
      ALUOP_LB:  result_o = {{24{byte_lane[7]}}, byte_lane};
      ALUOP_LBU: result_o = {24'h0, byte_lane};
      ALUOP_LH:  result_o = {{16{half_lane[15]}}, half_lane};
      ALUOP_LHU: result_o = {16'h0, half_lane};
      default:   result_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// rtl/mem_access.sv - memory-access pipeline stage driving the SRAM-like data bus
module mem_access
  import mem_access_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      exception,
  input  logic                      mem_advance,
  input  logic [ALUOP_BUS-1:0]      mem_aluop,
  input  logic [EXCEP_TYPE_BUS-1:0] mem_exception_type,
  input  logic                      mem_mem_to_reg,
  input  logic                      mem_ram_write_enable,
  input  logic [RAM_ADDR_BUS-1:0]   mem_ram_read_addr,
  input  logic [RAM_ADDR_BUS-1:0]   mem_ram_write_addr,
  input  logic [GPR_BUS-1:0]        mem_ram_write_data,
  input  logic [GPR_BUS-1:0]        mem_alu_data,
  mem_access_if.master              bus,
  output logic                      data_stall,
  output logic [GPR_BUS-1:0]        wb_data,
  output logic [EXCEP_TYPE_BUS-1:0] excep_type_out,
  output logic [RAM_ADDR_BUS-1:0]   bad_vaddr
);

  state_e             state_q, state_d;
  logic [GPR_BUS-1:0] ld_buf_q, ld_buf_d;

  logic [RAM_ADDR_BUS-1:0] addr;
  logic                    is_mem;
  logic                    is_half;
  logic                    is_word;
  logic                    misaligned;
  logic                    access_needed;
  logic [GPR_BUS-1:0]      ld_ext;

  // Read and write addresses are the same effective address; pick by op kind.
  assign addr    = mem_mem_to_reg ? mem_ram_read_addr : mem_ram_write_addr;
  assign is_mem  = mem_mem_to_reg | mem_ram_write_enable;
  assign is_half = (mem_aluop == ALUOP_LH) || (mem_aluop == ALUOP_LHU) || (mem_aluop == ALUOP_SH);
  assign is_word = (mem_aluop == ALUOP_LW) || (mem_aluop == ALUOP_SW);

  assign misaligned    = is_mem & ((is_half & addr[0]) | (is_word & (addr[1:0] != 2'b00)));
  assign access_needed = is_mem & (mem_exception_type == '0) & ~misaligned;

  mem_access_load_align u_load_align (
    .aluop_i   (mem_aluop),
    .addr_lo_i (addr[1:0]),
    .rdata_i   (bus.data_rdata),
    .result_o  (ld_ext)
  );

  // Merge address-error bits into the exception vector carried down the pipe.
  always_comb begin
    excep_type_out = mem_exception_type;
    if (misaligned && mem_mem_to_reg)       excep_type_out[EXCEP_ADEL_BIT] = 1'b1;
    if (misaligned && mem_ram_write_enable) excep_type_out[EXCEP_ADES_BIT] = 1'b1;
    bad_vaddr = misaligned ? addr : '0;
  end

  // Bus request fields: size code and lane-replicated store data.
  always_comb begin
    bus.data_wr   = mem_ram_write_enable;
    bus.data_addr = addr;
    bus.data_req  = (state_q == ST_IDLE) & access_needed & ~exception;
    if (is_half)      bus.data_size = SIZE_HALF;
    else if (is_word) bus.data_size = SIZE_WORD;
    else              bus.data_size = SIZE_BYTE;
    case (mem_aluop)
      ALUOP_SB: bus.data_wdata = {4{mem_ram_write_data[7:0]}};
      ALUOP_SH: bus.data_wdata = {2{mem_ram_write_data[15:0]}};
      default:  bus.data_wdata = mem_ram_write_data;
    endcase
  end

  // Stall upstream while a transaction is outstanding; choose write-back source.
  always_comb begin
    case (state_q)
      ST_IDLE:      data_stall = access_needed;
      ST_WAIT_DATA: data_stall = ~bus.data_ok;
      ST_DONE:      data_stall = 1'b0;
      default:      data_stall = 1'b1;
    endcase
    if (state_q == ST_DONE) wb_data = ld_buf_q;
    else if (mem_mem_to_reg) wb_data = ld_ext;
    else                     wb_data = mem_alu_data;
  end

  // Next-state logic: DONE holds a finished load until ex_mem advances,
  // DRAIN swallows the response of a flushed access.
  always_comb begin
    state_d  = state_q;
    ld_buf_d = ld_buf_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.data_req && bus.data_addr_ok) state_d = ST_WAIT_DATA;
      end
      ST_WAIT_DATA: begin
        if (bus.data_ok) begin
          ld_buf_d = ld_ext;
          if (exception || mem_advance) state_d = ST_IDLE;
          else                          state_d = ST_DONE;
        end else if (exception) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DONE: begin
        if (mem_advance || exception) state_d = ST_IDLE;
      end
      default: begin
        if (bus.data_ok) state_d = ST_IDLE;
      end
    endcase
  end

  // State and load-buffer registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      ld_buf_q <= '0;
    end else begin
      state_q  <= state_d;
      ld_buf_q <= ld_buf_d;
    end
  end

endmodule

// File: doc/mem_access.md
# mem_access

Memory-access stage of the CPU pipeline. Consumes the ex_mem register outputs and performs loads and stores over the SRAM-like data bus. Handles byte/halfword/word alignment, sign/zero extension and address-error detection, and produces the register write-back value. Drives `data_stall` back to ex_mem and upstream stages while a bus transaction is outstanding.

## Interface
Parameters:
- none; all widths come from the shared defines (`GPR_BUS` 32, `ALUOP_BUS` 8, `EXCEP_TYPE_BUS` 32, `RAM_ADDR_BUS` 32).

Ports:
- `clk`  in  1  pipeline clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `exception`  in  1  pipeline flush from the exception unit.
- `mem_advance`  in  1  ex_mem loads a new entry at the next edge.
- `mem_aluop`  in  8  memory op: LB, LBU, LH, LHU, LW, SB, SH, SW, or other.
- `mem_exception_type`  in  32  exceptions accumulated by earlier stages.
- `mem_mem_to_reg`  in  1  instruction is a load.
- `mem_ram_write_enable`  in  1  instruction is a store.
- `mem_ram_read_addr`, `mem_ram_write_addr`  in  32  effective address; always equal to each other.
- `mem_ram_write_data`  in  32  store source register value.
- `mem_alu_data`  in  32  non-load write-back value.
- `data_req`  out  1  bus request.
- `data_wr`  out  1  1 = store.
- `data_size`  out  2  0 = byte, 1 = half, 2 = word.
- `data_addr`  out  32  byte address.
- `data_wdata`  out  32  store data, lane-replicated.
- `data_addr_ok`  in  1  request accepted.
- `data_ok`  in  1  transaction complete.
- `data_rdata`  in  32  load data, word-aligned.
- `data_stall`  out  1  hold ex_mem and earlier stages.
- `wb_data`  out  32  register write-back value.
- `excep_type_out`  out  32  `mem_exception_type` with bit 4 (AdEL) / bit 5 (AdES) ORed in.
- `bad_vaddr`  out  32  faulting address, else 0.

## Operation
- An access is needed when (load or store) and `mem_exception_type == 0` and no alignment error.
- Alignment error: half-word op with addr[0] = 1, or word op with addr[1:0] != 0.
  - Load misalignment sets bit 4; store misalignment sets bit 5.
  - `bad_vaddr` = address. No bus request is issued.
- Store data lanes:
  - SB: `{4{wdata[7:0]}}`.
  - SH: `{2{wdata[15:0]}}`.
  - SW: `wdata` unchanged.
- Load data: select the byte/half lane by addr[1:0]; LB/LH sign-extend, LBU/LHU zero-extend.
- `wb_data` source:
  - loads: extended load data;
  - everything else: `mem_alu_data`.
- FSM states: IDLE, WAIT_DATA, DONE, DRAIN.
  - IDLE:
    - `data_req` = access needed & !exception (combinational).
    - On `data_addr_ok` & `data_req` -> WAIT_DATA.
    - `data_stall` = access needed.
  - WAIT_DATA:
    - `data_req` = 0; `data_stall` = !`data_ok`.
    - On `data_ok`: capture the extended load data into `ld_buf`; go to DONE if !`mem_advance`, else IDLE.
    - `exception` without `data_ok` -> DRAIN.
  - DONE:
    - Instruction already completed; `wb_data` comes from `ld_buf`; no re-request; `data_stall` = 0.
    - `mem_advance` or `exception` -> IDLE.
  - DRAIN:
    - `data_req` = 0; `data_stall` = 1; load data is discarded.
    - `data_ok` -> IDLE.
- While `exception` = 1: no new request, and `wb_data` is still driven as above.

## Timing
- Reset: state IDLE, `ld_buf` = 0. Outputs are combinational, so with ex_mem in reset (all zero) every output is 0.
- Request can be accepted in the cycle it is raised (`addr_ok` same cycle). `data_ok` can arrive no earlier than the next cycle.
- Fastest load: 2 cycles, `data_stall` high for exactly 1 cycle. Load data is valid combinationally in the `data_ok` cycle.
- `data_req`/`data_addr`/`data_wdata`/`data_size` stay stable while waiting for `addr_ok`.
- An exception arriving in the same cycle as `data_ok` -> IDLE; the load result is dropped because the flush clears ex_mem.
- Reset mid-transaction: FSM returns to IDLE immediately; bus-side recovery is the interconnect's reset.

## Structure
- Aluop encodings, `EXCEP_ADEL_BIT` = 4 and `EXCEP_ADES_BIT` = 5, the FSM state encoding and the size codes all go in `defines.v`.
- Sub-module `load_align`: combinational lane select and extension (aluop, addr[1:0], rdata -> 32-bit result). It is reused for `ld_buf` capture.

## Test plan
- LW at 0x1000, `addr_ok` immediate, `data_ok` next cycle with rdata = 0xDEADBEEF -> `data_stall` high 1 cycle, `wb_data` = 0xDEADBEEF.
- LB at 0x1003, rdata = 0x80FF0000 -> `wb_data` = 0xFFFFFF80; same access with LBU -> 0x00000080.
- SH at 0x2002 with wdata = 0x1234ABCD -> `data_wr` = 1, `data_size` = 1, `data_wdata` = 0xABCDABCD.
- LW at 0x1002 -> no `data_req`, `excep_type_out` bit 4 set, `bad_vaddr` = 0x1002, `data_stall` = 0.
- Load in WAIT_DATA, `exception` pulsed, `data_ok` 3 cycles later -> DRAIN with `data_stall` = 1 until `data_ok`, no new `data_req`, then IDLE.
- Load completes while `mem_advance` = 0 for 2 cycles -> DONE, no second `data_req`, `wb_data` held from `ld_buf`; reset asserted in WAIT_DATA -> IDLE, `data_req` = 0.
